// File: rtl/bnn_result_reader.sv
// Waits for the combinational BNN output to settle, captures the class scores,
// finds the winning class and streams {class, scores} as a ready/valid byte frame.
module bnn_result_reader #(
    parameter int N_CLASSES     = 10,
    parameter int SCORE_W       = 7,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_i,
    input  logic [N_CLASSES-1:0][SCORE_W-1:0] layer_i,
    output logic                              busy_o,
    output logic [3:0]                        class_o,
    output logic                              class_valid_o,
    output logic [7:0]                        tx_data_o,
    output logic                              tx_valid_o,
    input  logic                              tx_ready_i,
    output logic                              tx_last_o,
    output logic                              done_o
);

    localparam int IDX_W = $clog2(N_CLASSES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        SCAN,
        SEND,
        DONE
    } state_t;

    state_t state, next_state;

    logic [3:0]                        settle_cnt;
    logic [IDX_W-1:0]                  cnt;
    logic [N_CLASSES-1:0][SCORE_W-1:0] scores;
    logic [SCORE_W-1:0]                best;
    logic [3:0]                        best_idx;
    logic [3:0]                        class_q;
    logic                              class_valid_q;
    logic                              cnt_at_end;

    // cnt doubles as the scan index and the frame byte index; both end at N_CLASSES
    assign cnt_at_end = (cnt == IDX_W'(N_CLASSES));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_i) next_state = SETTLE;
            SETTLE:  if (settle_cnt == 4'd1) next_state = CAPTURE;
            CAPTURE: next_state = SCAN;
            SCAN:    if (cnt_at_end) next_state = SEND;
            SEND:    if (tx_ready_i && cnt_at_end) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            settle_cnt    <= '0;
            cnt           <= '0;
            class_q       <= '0;
            class_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) settle_cnt <= 4'(SETTLE_CYCLES);
                end
                SETTLE: settle_cnt <= settle_cnt - 4'd1;
                CAPTURE: begin
                    cnt           <= '0;
                    class_valid_q <= 1'b0;
                end
                SCAN: begin
                    // the extra cycle after the last compare commits the winner
                    if (cnt_at_end) begin
                        class_q       <= best_idx;
                        class_valid_q <= 1'b1;
                        cnt           <= '0;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                SEND: begin
                    if (tx_ready_i) cnt <= cnt + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always rewritten in CAPTURE
    always_ff @(posedge clk_i) begin
        if (state == CAPTURE) begin
            scores   <= layer_i;
            best     <= '0;
            best_idx <= '0;
        end else if (state == SCAN && !cnt_at_end) begin
            if (scores[cnt] > best) begin
                best     <= scores[cnt];
                best_idx <= 4'(cnt);
            end
        end
    end

    always_comb begin
        busy_o        = (state != IDLE);
        tx_valid_o    = (state == SEND);
        tx_last_o     = (state == SEND) && cnt_at_end;
        done_o        = (state == DONE);
        class_o       = class_q;
        class_valid_o = class_valid_q;
        tx_data_o     = 8'd0;
        if (state == SEND) begin
            if (cnt == '0) tx_data_o = {4'b0000, class_q};
            else           tx_data_o = 8'(scores[cnt - IDX_W'(1)]);
        end
    end

endmodule

// File: tb/tb_bnn_result_reader.sv
// Directed bench for bnn_result_reader: frame contents, latency, ties,
// backpressure, reset abort and ignored start pulses.
module tb_bnn_result_reader;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [9:0][6:0] layer;
    logic            busy;
    logic [3:0]      class_o;
    logic            class_valid;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            tx_last;
    logic            done;

    int n_tests = 0;
    int n_fail  = 0;

    bnn_result_reader #(
        .N_CLASSES(10),
        .SCORE_W(7),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .start_i(start),
        .layer_i(layer),
        .busy_o(busy),
        .class_o(class_o),
        .class_valid_o(class_valid),
        .tx_data_o(tx_data),
        .tx_valid_o(tx_valid),
        .tx_ready_i(tx_ready),
        .tx_last_o(tx_last),
        .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // rnd: random tx_ready; poke: start pulses while busy; abort: reset at 5th byte;
    // lat: check latency and disturb layer after capture
    task automatic run_frame(input logic [9:0][6:0] sc, input int exp_cls,
                             input bit rnd, input bit poke, input bit abort, input bit lat);
        logic [7:0] exp_b [11];
        logic [7:0] prev;
        bit         stalled;
        int         c, k, guard;
        exp_b[0] = 8'(exp_cls);
        for (int i = 0; i < 10; i++) exp_b[i+1] = {1'b0, sc[i]};
        layer = sc;
        start = 1'b1;
        step();
        start = 1'b0;
        c = 0;
        while (!tx_valid && c < 100) begin
            if (lat && c == 3) layer = ~sc;
            start = poke && (c == 6);
            step();
            c++;
        end
        start = 1'b0;
        check("valid_seen", tx_valid, 1);
        if (lat) check("latency", c, 14);
        check("class", class_o, exp_cls);
        check("class_valid", class_valid, 1);
        k = 0;
        guard = 0;
        stalled = 1'b0;
        prev = 8'd0;
        while (k < 11 && guard < 400) begin
            if (abort && k == 4) begin
                rst_n = 1'b0;
                tx_ready = 1'b0;
                step();
                rst_n = 1'b1;
                check("abort_valid", tx_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                step();
                check("abort_done2", done, 0);
                return;
            end
            check("valid_hold", tx_valid, 1);
            if (stalled) begin
                check("stall_data", tx_data, prev);
                check("stall_last", tx_last, k == 10);
            end
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_ready) begin
                check($sformatf("byte%0d", k), tx_data, exp_b[k]);
                check($sformatf("last%0d", k), tx_last, k == 10);
                k++;
            end
            start = poke && (k == 3);
            prev = tx_data;
            stalled = !tx_ready;
            step();
            guard++;
        end
        start = 1'b0;
        tx_ready = 1'b0;
        check("frame_len", k, 11);
        check("done_pulse", done, 1);
        check("class_hold", class_o, exp_cls);
        step();
        check("done_clear", done, 0);
        check("idle_busy", busy, 0);
        if (poke) begin
            step();
            step();
            check("no_second_frame", busy, 0);
        end
    endtask

    initial begin
        logic [9:0][6:0] v;
        rst_n = 1'b0;
        start = 1'b1;
        tx_ready = 1'b0;
        layer = '0;
        step();
        step();
        start = 1'b0;
        rst_n = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_class", class_o, 0);
        check("rst_class_valid", class_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_last", tx_last, 0);
        check("rst_done", done, 0);
        step();
        check("rst_start_ignored", busy, 0);

        v = '0;
        v[0] = 7'd3; v[1] = 7'd9; v[2] = 7'd1; v[9] = 7'd120;
        run_frame(v, 9, 1'b0, 1'b0, 1'b0, 1'b1);

        v = '0;
        v[2] = 7'd50; v[7] = 7'd50;
        run_frame(v, 2, 1'b0, 1'b0, 1'b0, 1'b0);

        v = '0;
        v[0] = 7'd17; v[3] = 7'd127; v[4] = 7'd64; v[8] = 7'd127;
        run_frame(v, 3, 1'b1, 1'b0, 1'b0, 1'b0);

        v = '0;
        v[0] = 7'd5; v[5] = 7'd99; v[6] = 7'd98;
        run_frame(v, 5, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame(v, 5, 1'b0, 1'b0, 1'b0, 1'b0);

        v = '0;
        v[1] = 7'd44; v[9] = 7'd45;
        run_frame(v, 9, 1'b0, 1'b1, 1'b0, 1'b0);

        v = '0;
        run_frame(v, 0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bnn_result_reader.md
BNN_RESULT_READER -- requirements
Module: bnn_result_reader

Interface
REQ-001 SHALL have parameter N_CLASSES, default 10: number of class scores presented by the BNN output.
REQ-002 SHALL have parameter SCORE_W, default 7: width of each class score, unsigned.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 2, legal range 1..15: wait cycles for the combinational BNN path to settle.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port start_i, input, 1 bit: a new image is stable on the BNN input; honoured only in IDLE.
REQ-007 SHALL have port layer_i, input, [N_CLASSES-1:0][SCORE_W-1:0]: class scores from the BNN layer_o.
REQ-008 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port class_o, output, 4 bits: index of the winning class.
REQ-010 SHALL have port class_valid_o, output, 1 bit: class_o holds a valid result.
REQ-011 SHALL have port tx_data_o, output, 8 bits: result frame byte.
REQ-012 SHALL have port tx_valid_o, output, 1 bit: tx_data_o is valid.
REQ-013 SHALL have port tx_ready_i, input, 1 bit: downstream accepts the byte.
REQ-014 SHALL have port tx_last_o, output, 1 bit: marks the final byte of a frame.
REQ-015 SHALL have port done_o, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-016 SHALL implement FSM states IDLE, SETTLE, CAPTURE, SCAN, SEND, DONE.
REQ-017 In IDLE, start_i=1 SHALL move to SETTLE and load the settle counter with SETTLE_CYCLES; start_i SHALL be ignored in every other state.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then move to CAPTURE.
REQ-019 CAPTURE SHALL register all N_CLASSES scores from layer_i in one cycle, clear class_valid_o, then move to SCAN; layer_i changes after CAPTURE SHALL NOT affect the result.
REQ-020 SCAN SHALL compare one captured score per cycle for N_CLASSES cycles, index 0 first, using an unsigned strictly-greater compare, so ties resolve to the lowest index.
REQ-021 On leaving SCAN, class_o SHALL be set to the winning index and class_valid_o to 1; both SHALL hold until the next CAPTURE or reset.
REQ-022 Latency SHALL be fixed: with start_i sampled at edge 0, the first SEND cycle occurs at edge SETTLE_CYCLES+N_CLASSES+2; class_valid_o is high in that cycle.
REQ-023 The SEND frame SHALL be N_CLASSES+1 bytes: byte 0 is {4'b0, class_o}; bytes 1..N_CLASSES are scores 0..N_CLASSES-1, zero-extended to 8 bits.
REQ-024 A byte transfer SHALL occur only on a cycle where tx_valid_o=1 and tx_ready_i=1.
REQ-025 tx_data_o and tx_last_o SHALL stay stable while tx_valid_o=1 and tx_ready_i=0.
REQ-026 tx_valid_o SHALL NOT depend combinationally on tx_ready_i.
REQ-027 tx_valid_o SHALL be high throughout SEND, so back-to-back transfers run at one byte per cycle when tx_ready_i stays 1.
REQ-028 tx_last_o SHALL be 1 only with the final byte.
REQ-029 The transfer of the final byte SHALL move to DONE; DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-030 tx_ready_i held at 0 SHALL stall SEND indefinitely with no byte lost or duplicated.
REQ-031 start_i asserted in DONE SHALL be ignored; start_i in the following IDLE cycle SHALL be accepted.

Reset
REQ-032 With rst_ni=0 at a rising edge, the next state SHALL be IDLE and outputs SHALL be: busy_o=0, class_o=0, class_valid_o=0, tx_data_o=0, tx_valid_o=0, tx_last_o=0, done_o=0.
REQ-033 Reset asserted in any state, including mid-SEND with an unaccepted byte, SHALL abort the frame without completing it and without a done_o pulse.
REQ-034 start_i sampled in the same cycle as rst_ni=0 SHALL be ignored.

Verification
REQ-035 Scores {3,9,1,0,0,0,0,0,0,120}, tx_ready_i=1 -> class_o=9; bytes 09,03,09,01,00,00,00,00,00,00,78; tx_last_o on the 11th byte; done_o one cycle later.
REQ-036 Tie: scores 50 at indices 2 and 7, all others 0 -> class_o=2.
REQ-037 Latency: SETTLE_CYCLES=2, start_i at edge 0 -> tx_valid_o first high in the cycle after edge 14; layer_i changed at edge 4 -> frame unchanged.
REQ-038 Backpressure: tx_ready_i toggled 0/1 randomly -> 11 bytes exactly, in order, tx_data_o stable during stalls.
REQ-039 Reset at the 5th SEND byte -> tx_valid_o=0 and busy_o=0 next cycle, no done_o; a new start_i then yields a full correct frame.
REQ-040 start_i pulsed during SCAN and SEND -> ignored; exactly one frame is produced.
